// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes an instruction into the 3-bit ALU code, forwards
// operands from EX/MEM and MEM/WB, and registers the result for the EX stage.
module alu_issue_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [31:0]           instr_i,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic                  exmem_regwrite_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]       exmem_result_i,
  input  logic                  memwb_regwrite_i,
  input  logic [REG_ADDR_W-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]       memwb_result_i,
  output logic                  valid_o,
  output logic [2:0]            alu_ctrl_o,
  output logic [XLEN-1:0]       data1_o,
  output logic [XLEN-1:0]       data2_o,
  output logic [XLEN-1:0]       store_data_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  regwrite_o,
  output logic                  memread_o,
  output logic                  memwrite_o,
  output logic                  branch_o,
  output logic                  illegal_o
);

  // ALU code encoding is shared with the ALU and must not change
  localparam logic [2:0] ALU_SLL  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_MUL  = 3'b110;
  localparam logic [2:0] ALU_SRAI = 3'b111;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [REG_ADDR_W-1:0] rs1_idx;
  logic [REG_ADDR_W-1:0] rs2_idx;
  logic [REG_ADDR_W-1:0] rd_idx;

  assign opcode  = instr_i[6:0];
  assign rd_idx  = instr_i[11:7];
  assign funct3  = instr_i[14:12];
  assign rs1_idx = instr_i[19:15];
  assign rs2_idx = instr_i[24:20];
  assign funct7  = instr_i[31:25];

  logic            dec_legal;
  logic [2:0]      dec_ctrl;
  logic            dec_regwrite;
  logic            dec_memread;
  logic            dec_memwrite;
  logic            dec_branch;
  logic            dec_use_imm;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    dec_legal    = 1'b0;
    dec_ctrl     = ALU_ADD;
    dec_regwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_branch   = 1'b0;
    dec_use_imm  = 1'b0;
    dec_imm      = '0;
    case (opcode)
      OP_R: begin
        dec_legal    = 1'b1;
        dec_regwrite = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: dec_ctrl = ALU_ADD;
          10'b0100000_000: dec_ctrl = ALU_SUB;
          10'b0000001_000: dec_ctrl = ALU_MUL;
          10'b0000000_111: dec_ctrl = ALU_AND;
          10'b0000000_110: dec_ctrl = ALU_OR;
          10'b0000000_100: dec_ctrl = ALU_XOR;
          10'b0000000_001: dec_ctrl = ALU_SLL;
          default: begin
            dec_legal    = 1'b0;
            dec_regwrite = 1'b0;
          end
        endcase
      end
      OP_I: begin
        dec_use_imm = 1'b1;
        if (funct3 == 3'b000) begin
          dec_legal    = 1'b1;
          dec_regwrite = 1'b1;
          dec_ctrl     = ALU_ADD;
          dec_imm      = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
        end else if (funct3 == 3'b101 && funct7 == 7'b0100000) begin
          dec_legal    = 1'b1;
          dec_regwrite = 1'b1;
          dec_ctrl     = ALU_SRAI;
          dec_imm      = {{(XLEN-5){1'b0}}, instr_i[24:20]};
        end
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          dec_legal    = 1'b1;
          dec_regwrite = 1'b1;
          dec_memread  = 1'b1;
          dec_use_imm  = 1'b1;
          dec_imm      = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          dec_legal    = 1'b1;
          dec_memwrite = 1'b1;
          dec_use_imm  = 1'b1;
          dec_imm      = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        end
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000) begin
          dec_legal  = 1'b1;
          dec_branch = 1'b1;
          dec_ctrl   = ALU_SUB;
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // EX/MEM is checked first so the younger result wins; x0 never forwards
  logic            exmem_hit1, exmem_hit2, memwb_hit1, memwb_hit2;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  assign exmem_hit1 = exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rs1_idx);
  assign exmem_hit2 = exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rs2_idx);
  assign memwb_hit1 = memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rs1_idx);
  assign memwb_hit2 = memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rs2_idx);

  assign fwd_rs1 = exmem_hit1 ? exmem_result_i :
                   memwb_hit1 ? memwb_result_i : rs1_data_i;
  assign fwd_rs2 = exmem_hit2 ? exmem_result_i :
                   memwb_hit2 ? memwb_result_i : rs2_data_i;

  logic                  valid_d, regwrite_d, memread_d, memwrite_d, branch_d, illegal_d;
  logic [2:0]            alu_ctrl_d;
  logic [XLEN-1:0]       data1_d, data2_d, store_data_d;
  logic [REG_ADDR_W-1:0] rd_d;

  always_comb begin
    valid_d      = 1'b0;
    regwrite_d   = 1'b0;
    memread_d    = 1'b0;
    memwrite_d   = 1'b0;
    branch_d     = 1'b0;
    illegal_d    = 1'b0;
    alu_ctrl_d   = ALU_ADD;
    data1_d      = '0;
    data2_d      = '0;
    store_data_d = '0;
    rd_d         = '0;
    if (valid_i) begin
      valid_d = 1'b1;
      if (dec_legal) begin
        regwrite_d   = dec_regwrite;
        memread_d    = dec_memread;
        memwrite_d   = dec_memwrite;
        branch_d     = dec_branch;
        alu_ctrl_d   = dec_ctrl;
        data1_d      = fwd_rs1;
        data2_d      = dec_use_imm ? dec_imm : fwd_rs2;
        store_data_d = fwd_rs2;
        rd_d         = dec_regwrite ? rd_idx : '0;
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  logic                  valid_q, regwrite_q, memread_q, memwrite_q, branch_q, illegal_q;
  logic [2:0]            alu_ctrl_q;
  logic [XLEN-1:0]       data1_q, data2_q, store_data_q;
  logic [REG_ADDR_W-1:0] rd_q;

  // Reset and flush both insert a bubble; stall holds the register
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      branch_q     <= 1'b0;
      illegal_q    <= 1'b0;
      alu_ctrl_q   <= ALU_ADD;
      data1_q      <= '0;
      data2_q      <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
    end else if (!stall_i) begin
      valid_q      <= valid_d;
      regwrite_q   <= regwrite_d;
      memread_q    <= memread_d;
      memwrite_q   <= memwrite_d;
      branch_q     <= branch_d;
      illegal_q    <= illegal_d;
      alu_ctrl_q   <= alu_ctrl_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      store_data_q <= store_data_d;
      rd_q         <= rd_d;
    end
  end

  assign valid_o      = valid_q;
  assign regwrite_o   = regwrite_q;
  assign memread_o    = memread_q;
  assign memwrite_o   = memwrite_q;
  assign branch_o     = branch_q;
  assign illegal_o    = illegal_q;
  assign alu_ctrl_o   = alu_ctrl_q;
  assign data1_o      = data1_q;
  assign data2_o      = data2_q;
  assign store_data_o = store_data_q;
  assign rd_o         = rd_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode, forwarding, stall/flush and
// illegal-encoding cases with hand-computed expected register contents.
module tb_alu_issue_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i, valid_i;
  logic [31:0] instr_i, rs1_data_i, rs2_data_i;
  logic        exmem_regwrite_i, memwb_regwrite_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic [31:0] exmem_result_i, memwb_result_i;
  logic        valid_o, regwrite_o, memread_o, memwrite_o, branch_o, illegal_o;
  logic [2:0]  alu_ctrl_o;
  logic [31:0] data1_o, data2_o, store_data_o;
  logic [4:0]  rd_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  alu_issue_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .instr_i(instr_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i),
    .exmem_result_i(exmem_result_i),
    .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i),
    .memwb_result_i(memwb_result_i),
    .valid_o(valid_o), .alu_ctrl_o(alu_ctrl_o), .data1_o(data1_o),
    .data2_o(data2_o), .store_data_o(store_data_o), .rd_o(rd_o),
    .regwrite_o(regwrite_o), .memread_o(memread_o), .memwrite_o(memwrite_o),
    .branch_o(branch_o), .illegal_o(illegal_o)
  );

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [2:0] ctrl,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] st, input logic [4:0] rd,
                           input logic rw, input logic mr, input logic mw,
                           input logic br, input logic ill);
    check({tag, ".valid"},    {31'd0, valid_o},    {31'd0, v});
    check({tag, ".ctrl"},     {29'd0, alu_ctrl_o}, {29'd0, ctrl});
    check({tag, ".data1"},    data1_o,             d1);
    check({tag, ".data2"},    data2_o,             d2);
    check({tag, ".store"},    store_data_o,        st);
    check({tag, ".rd"},       {27'd0, rd_o},       {27'd0, rd});
    check({tag, ".regwrite"}, {31'd0, regwrite_o}, {31'd0, rw});
    check({tag, ".memread"},  {31'd0, memread_o},  {31'd0, mr});
    check({tag, ".memwrite"}, {31'd0, memwrite_o}, {31'd0, mw});
    check({tag, ".branch"},   {31'd0, branch_o},   {31'd0, br});
    check({tag, ".illegal"},  {31'd0, illegal_o},  {31'd0, ill});
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    valid_i = 1'b1;
    instr_i = ins;
    step();
  endtask

  task automatic fwd_off();
    exmem_regwrite_i = 1'b0; exmem_rd_i = 5'd0; exmem_result_i = 32'h0;
    memwb_regwrite_i = 1'b0; memwb_rd_i = 5'd0; memwb_result_i = 32'h0;
  endtask

  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] I = 7'b0010011;

  initial begin
    // reset with random inputs
    #1;
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b1;
    instr_i = $urandom; rs1_data_i = $urandom; rs2_data_i = $urandom;
    exmem_regwrite_i = 1'b1; exmem_rd_i = 5'($urandom); exmem_result_i = $urandom;
    memwb_regwrite_i = 1'b1; memwb_rd_i = 5'($urandom); memwb_result_i = $urandom;
    step();
    instr_i = $urandom; rs1_data_i = $urandom;
    step();
    check_all("reset", 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst_i = 1'b0;
    fwd_off();
    rs1_data_i = 32'h10; rs2_data_i = 32'h3;

    issue(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, R));
    check_all("add", 1, 3'b001, 32'h10, 32'h3, 32'h3, 5'd3, 1, 0, 0, 0, 0);
    issue(enc(7'h20, 5'd2, 5'd1, 3'b000, 5'd3, R));
    check_all("sub", 1, 3'b010, 32'h10, 32'h3, 32'h3, 5'd3, 1, 0, 0, 0, 0);
    issue(enc(7'h01, 5'd2, 5'd1, 3'b000, 5'd4, R));
    check_all("mul", 1, 3'b110, 32'h10, 32'h3, 32'h3, 5'd4, 1, 0, 0, 0, 0);
    issue(enc(7'h00, 5'd2, 5'd1, 3'b001, 5'd5, R));
    check_all("sll", 1, 3'b000, 32'h10, 32'h3, 32'h3, 5'd5, 1, 0, 0, 0, 0);
    issue(enc(7'h00, 5'd2, 5'd1, 3'b111, 5'd6, R));
    check("and.ctrl", {29'd0, alu_ctrl_o}, 32'd3);
    issue(enc(7'h00, 5'd2, 5'd1, 3'b110, 5'd6, R));
    check("or.ctrl", {29'd0, alu_ctrl_o}, 32'd4);
    issue(enc(7'h00, 5'd2, 5'd1, 3'b100, 5'd6, R));
    check("xor.ctrl", {29'd0, alu_ctrl_o}, 32'd5);

    // srai x5,x6,4
    issue(enc(7'h20, 5'd4, 5'd6, 3'b101, 5'd5, I));
    check_all("srai", 1, 3'b111, 32'h10, 32'h4, 32'h3, 5'd5, 1, 0, 0, 0, 0);
    // addi x1,x2,-1
    issue({12'hFFF, 5'd2, 3'b000, 5'd1, I});
    check_all("addi", 1, 3'b001, 32'h10, 32'hFFFF_FFFF, 32'h3, 5'd1, 1, 0, 0, 0, 0);
    // lw x4,8(x2)
    issue({12'h008, 5'd2, 3'b010, 5'd4, 7'b0000011});
    check_all("lw", 1, 3'b001, 32'h10, 32'h8, 32'h3, 5'd4, 1, 1, 0, 0, 0);
    // sw x7,-4(x8)
    issue(enc(7'h7F, 5'd7, 5'd8, 3'b010, 5'h1C, 7'b0100011));
    check_all("sw", 1, 3'b001, 32'h10, 32'hFFFF_FFFC, 32'h3, 5'd0, 0, 0, 1, 0, 0);
    // beq x1,x2
    issue(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011));
    check_all("beq", 1, 3'b010, 32'h10, 32'h3, 32'h3, 5'd0, 0, 0, 0, 1, 0);

    // forwarding: add x3,x1,x1, both stages match -> EX/MEM wins
    exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd1; exmem_result_i = 32'hAA;
    memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd1; memwb_result_i = 32'hBB;
    issue(enc(7'h00, 5'd1, 5'd1, 3'b000, 5'd3, R));
    check("fwd_both.data1", data1_o, 32'hAA);
    check("fwd_both.data2", data2_o, 32'hAA);
    exmem_rd_i = 5'd9;
    issue(enc(7'h00, 5'd1, 5'd1, 3'b000, 5'd3, R));
    check("fwd_memwb.data1", data1_o, 32'hBB);
    check("fwd_memwb.data2", data2_o, 32'hBB);
    exmem_regwrite_i = 1'b0; exmem_rd_i = 5'd1;
    issue(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, R));
    check("fwd_nowrite.data1", data1_o, 32'hBB);
    check("fwd_nowrite.data2", data2_o, 32'h3);
    // x0 sources with x0 destinations: register file values
    exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd0; memwb_rd_i = 5'd0;
    issue(enc(7'h00, 5'd0, 5'd0, 3'b000, 5'd3, R));
    check("fwd_x0.data1", data1_o, 32'h10);
    check("fwd_x0.data2", data2_o, 32'h3);
    fwd_off();

    // stall: hold add for 3 cycles while inputs change
    issue(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, R));
    stall_i = 1'b1;
    exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd1; exmem_result_i = 32'hCC;
    issue(enc(7'h20, 5'd2, 5'd1, 3'b000, 5'd7, R));
    check_all("stall1", 1, 3'b001, 32'h10, 32'h3, 32'h3, 5'd3, 1, 0, 0, 0, 0);
    rs1_data_i = 32'h55;
    issue(enc(7'h01, 5'd2, 5'd1, 3'b000, 5'd8, R));
    check_all("stall2", 1, 3'b001, 32'h10, 32'h3, 32'h3, 5'd3, 1, 0, 0, 0, 0);
    issue(enc(7'h7F, 5'd7, 5'd8, 3'b010, 5'h1C, 7'b0100011));
    check_all("stall3", 1, 3'b001, 32'h10, 32'h3, 32'h3, 5'd3, 1, 0, 0, 0, 0);
    flush_i = 1'b1;
    issue(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, R));
    check_all("stall_flush", 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stall_i = 1'b0; flush_i = 1'b0;
    fwd_off();
    rs1_data_i = 32'h10;

    // illegal opcode, then a valid add clears it
    issue(32'h0000_007F);
    check_all("illegal", 1, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    issue(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, R));
    check_all("after_illegal", 1, 3'b001, 32'h10, 32'h3, 32'h3, 5'd3, 1, 0, 0, 0, 0);
    // unsupported R-type funct is illegal too
    issue(enc(7'h20, 5'd2, 5'd1, 3'b111, 5'd3, R));
    check("bad_funct.illegal", {31'd0, illegal_o}, 32'd1);
    check("bad_funct.regwrite", {31'd0, regwrite_o}, 32'd0);

    // valid_i=0 loads a bubble
    issue(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, R));
    valid_i = 1'b0;
    step();
    check_all("invalid", 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset mid-stall
    issue(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, R));
    stall_i = 1'b1; rst_i = 1'b1;
    step();
    check_all("rst_stall", 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b0; stall_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue stage that feeds the ALU: decodes a RISC-V instruction into the 3-bit ALU control code, selects and forwards operands, and registers everything for the EX stage.
- Drives the ALU's data1/data2/ALUCtrl inputs directly from registers.
- Supports stall (hold) and flush (bubble) from the hazard unit.
- Latency is one cycle.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- stall_i  in  1  hold the pipeline register.
- flush_i  in  1  load a bubble.
- valid_i  in  1  instr_i holds a real instruction.
- instr_i  in  32  instruction from IF/ID.
- rs1_data_i  in  XLEN  register file read port 1.
- rs2_data_i  in  XLEN  register file read port 2.
- exmem_regwrite_i  in  1  EX/MEM writes rd.
- exmem_rd_i  in  REG_ADDR_W  EX/MEM destination.
- exmem_result_i  in  XLEN  EX/MEM ALU result.
- memwb_regwrite_i  in  1  MEM/WB writes rd.
- memwb_rd_i  in  REG_ADDR_W  MEM/WB destination.
- memwb_result_i  in  XLEN  MEM/WB writeback value.
- valid_o  out  1  EX stage holds a real instruction.
- alu_ctrl_o  out  3  ALU operation code.
- data1_o  out  XLEN  ALU operand 1.
- data2_o  out  XLEN  ALU operand 2.
- store_data_o  out  XLEN  forwarded rs2 value, used by sw.
- rd_o  out  REG_ADDR_W  destination register.
- regwrite_o, memread_o, memwrite_o, branch_o  out  1 each  stage control bits.
- illegal_o  out  1  unsupported encoding was issued.

Behaviour:
- ALU code encoding is fixed and shared with the ALU: SLL=000, ADD=001, SUB=010, AND=011, OR=100, XOR=101, MUL=110, SRAI=111.
- R-type (opcode 0110011), keyed on funct7/funct3:
  - 0000000/000 ADD; 0100000/000 SUB; 0000001/000 MUL.
  - 0000000/111 AND; 0000000/110 OR; 0000000/100 XOR; 0000000/001 SLL.
  - regwrite=1.
- I-ALU (opcode 0010011):
  - funct3=000 is addi: ADD with imm = sign-extended instr[31:20].
  - funct3=101 with funct7=0100000 is srai: SRAI with data2 = zero-extended instr[24:20].
  - regwrite=1.
- lw (0000011, funct3 010): ADD with sign-extended I-imm; memread=1, regwrite=1.
- sw (0100011, funct3 010): ADD with imm = sign-extended {instr[31:25], instr[11:7]}; memwrite=1, regwrite=0.
- beq (1100011, funct3 000): SUB with data2 = forwarded rs2; branch=1, regwrite=0. The branch target is not computed here.
- Any other encoding while valid_i=1:
  - registers illegal_o=1, valid_o=1, alu_ctrl ADD, operands 0;
  - regwrite, memread, memwrite and branch all 0.
- Forwarding is applied per source (rs1 = instr[19:15], rs2 = instr[24:20]) before the register:
  - If exmem_regwrite_i, exmem_rd_i != 0 and it matches the source: use exmem_result_i.
  - Else if the same holds for memwb: use memwb_result_i.
  - Else use the register file value.
  - Source x0 is never forwarded.
  - EX/MEM wins when both match.
- rd_o = instr[11:7] for regwrite instructions, otherwise 0.
- Pipeline register update priority each rising edge:
  1. rst_i
  2. flush_i
  3. stall_i
  4. load
- rst_i and flush_i both load a bubble:
  - valid_o=0, regwrite/memread/memwrite/branch/illegal all 0;
  - alu_ctrl_o=001 (ADD); data1_o, data2_o, store_data_o, rd_o all 0.
- stall_i=1 (with no flush) holds every output unchanged. Forwarding inputs are ignored during the hold; the hazard unit re-presents the instruction.
- flush_i together with stall_i yields a bubble (flush wins).
- valid_i=0 on a load cycle loads a bubble.
- Reset mid-stall also loads a bubble. No state other than the pipeline register exists.
- The hazard unit owns load-use detection and guarantees correctness; this block does not check memread for it.

Test Plan:
- Reset: drive rst_i high for 2 cycles with random inputs → valid_o=0, alu_ctrl_o=001, all data outputs 0.
- Decode sweep, all forwarding off, rs1_data=0x10, rs2_data=0x3 → next cycle:
  - add gives ctrl 001, data1 0x10, data2 0x3;
  - sub gives 010; mul gives 110; sll gives 000;
  - `srai x5,x6,4` gives ctrl 111, data2 0x4;
  - `addi x1,x2,-1` gives data2 0xFFFFFFFF.
- `sw x7,-4(x8)` → ctrl 001, data2 0xFFFFFFFC, store_data_o = rs2 value, memwrite_o=1, regwrite_o=0, rd_o=0.
- Forwarding for `add x3,x1,x1`:
  - exmem rd=1, result 0xAA and memwb rd=1, result 0xBB → data1=data2=0xAA (EX/MEM priority).
  - With exmem rd=0 and memwb rd=0 (x0 sources) → register file values.
- Stall for 3 cycles with instr_i changing each cycle → outputs constant. Stall plus flush → bubble.
- Illegal: opcode 1111111 with valid_i=1 → illegal_o=1, valid_o=1, regwrite_o=0. The next valid add clears illegal_o.
